// File: rtl/reg_muldiv_unit_if.sv
// Bus between the control unit / register_block and reg_muldiv_unit.
// Carries operands, the start/ready/busy/done handshake and the register write port.
// Optional build macro: MULDIV_SIGNED_EN adds the signed_op request bit.
interface reg_muldiv_unit_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              op;
`ifdef MULDIV_SIGNED_EN
  logic              signed_op;
`endif
  logic [WIDTH-1:0]  data_1;
  logic [WIDTH-1:0]  data_2;
  logic [ADDR_W-1:0] dest_addr;
  logic              ready;
  logic              busy;
  logic              done;
  logic              regWrite;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0]  write_data;
  logic [WIDTH-1:0]  result_hi;
  logic              div_zero;

  modport master (
    output start, op, data_1, data_2, dest_addr,
`ifdef MULDIV_SIGNED_EN
    output signed_op,
`endif
    input  ready, busy, done, regWrite, write_addr, write_data, result_hi, div_zero
  );

  modport slave (
    input  start, op, data_1, data_2, dest_addr,
`ifdef MULDIV_SIGNED_EN
    input  signed_op,
`endif
    output ready, busy, done, regWrite, write_addr, write_data, result_hi, div_zero
  );
endinterface

// File: rtl/reg_muldiv_unit.sv
// Iterative multiply/divide unit, one bit per clock (shift-add / restoring divide).
// Result goes back through the register write port; result_hi/div_zero are side outputs.
// Optional build macro: MULDIV_SIGNED_EN enables two's-complement operation via signed_op.
// Signed operations run the unsigned core on magnitudes and fix the signs on the last iteration,
// so latency is identical in both modes.
module reg_muldiv_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  reg_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic               op_q;
  logic               negA_q;
  logic               negB_q;
  logic [WIDTH-1:0]   opA_q;
  logic [WIDTH-1:0]   addend_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   writeData_q;
  logic [WIDTH-1:0]   resultHi_q;
  logic [ADDR_W-1:0]  writeAddr_q;
  logic               divZero_q;

  logic               accept;
  logic               lastIter;
  logic               signedIn;
  logic               negAIn;
  logic               negBIn;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               geq;

  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodSigned;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   finalLo;
  logic [WIDTH-1:0]   finalHi;
  logic               finalDz;

`ifdef MULDIV_SIGNED_EN
  assign signedIn = bus.signed_op;
`else
  assign signedIn = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && bus.start;
  assign lastIter = (state_q == BUSY) && (count_q == CNT_W'(WIDTH - 1));
  assign negAIn   = signedIn & bus.data_1[WIDTH-1];
  assign negBIn   = signedIn & bus.data_2[WIDTH-1];
  assign magA     = negAIn ? -bus.data_1 : bus.data_1;
  assign magB     = negBIn ? -bus.data_2 : bus.data_2;

  // State register: async reset drops straight back to IDLE, aborting any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start is only looked at in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (count_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; the register write strobe is the done pulse.
  always_comb begin
    bus.ready    = (state_q == IDLE);
    bus.busy     = (state_q == BUSY);
    bus.done     = (state_q == DONE);
    bus.regWrite = (state_q == DONE);
  end

  assign bus.write_addr = writeAddr_q;
  assign bus.write_data = writeData_q;
  assign bus.result_hi  = resultHi_q;
  assign bus.div_zero   = divZero_q;

  // One iteration: multiply adds/shifts right LSB-first, divide shifts left and trial-subtracts.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, addend_q};
    shifted = {acc_q, mq_q[WIDTH-1]};
    geq     = shifted >= {1'b0, addend_q};
    diff    = shifted[WIDTH-1:0] - addend_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    if (!op_q) begin
      if (mq_q[0]) {acc_d, mq_d} = {sum, mq_q[WIDTH-1:1]};
      else         {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
    end else if (geq) begin
      acc_d = diff;
      mq_d  = {mq_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = shifted[WIDTH-1:0];
      mq_d  = {mq_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result from the last iteration, with sign restoration and divide-by-zero override.
  always_comb begin
    prodMag    = {acc_d, mq_d};
    prodSigned = (negA_q ^ negB_q) ? -prodMag : prodMag;
    quot       = (negA_q ^ negB_q) ? -mq_d : mq_d;
    rem        = negA_q ? -acc_d : acc_d;
    finalLo    = quot;
    finalHi    = rem;
    finalDz    = 1'b0;
    if (!op_q) begin
      finalLo = prodSigned[WIDTH-1:0];
      finalHi = prodSigned[2*WIDTH-1:WIDTH];
    end else if (addend_q == '0) begin
      finalLo = '1;
      finalHi = opA_q;
      finalDz = 1'b1;
    end
  end

  // Datapath: capture operands at accept, iterate in BUSY, publish results on the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      op_q        <= 1'b0;
      negA_q      <= 1'b0;
      negB_q      <= 1'b0;
      opA_q       <= '0;
      addend_q    <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      writeData_q <= '0;
      resultHi_q  <= '0;
      writeAddr_q <= '0;
      divZero_q   <= 1'b0;
    end else if (accept) begin
      op_q        <= bus.op;
      negA_q      <= negAIn;
      negB_q      <= negBIn;
      opA_q       <= bus.data_1;
      addend_q    <= bus.op ? magB : magA;
      mq_q        <= bus.op ? magA : magB;
      acc_q       <= '0;
      count_q     <= '0;
      divZero_q   <= 1'b0;
      resultHi_q  <= '0;
      writeAddr_q <= bus.dest_addr;
    end else if (state_q == BUSY) begin
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      count_q <= count_q + CNT_W'(1);
      if (lastIter) begin
        writeData_q <= finalLo;
        resultHi_q  <= finalHi;
        divZero_q   <= finalDz;
      end
    end
  end

endmodule

// File: tb/tb_reg_muldiv_unit.sv
// Self-checking bench for reg_muldiv_unit: scoreboard of expected register writes,
// popped and compared whenever the unit pulses regWrite.
// Optional build macro: MULDIV_SIGNED_EN adds the signed-operation cases.
module tb_reg_muldiv_unit;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    int          doneCycle;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   fails  = 0;
  int   e0;
  exp_t sb[$];
  exp_t got;

  reg_muldiv_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus();

  reg_muldiv_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp accepts and done pulses.
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] dest, input logic [15:0] lo, input logic [15:0] hi, input logic dz);
    exp_t m;
    m.addr = dest;
    m.lo = lo;
    m.hi = hi;
    m.dz = dz;
    m.doneCycle = 0;
    return m;
  endfunction

  function automatic exp_t model(input logic opIn, input logic sgn, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] dest);
    logic [31:0] p;
    int sa, sbv, q, r;
    sa  = sgn ? int'($signed(a)) : int'(a);
    sbv = sgn ? int'($signed(b)) : int'(b);
    if (!opIn) begin
      if (sgn) p = 32'(sa * sbv);
      else     p = {16'h0, a} * {16'h0, b};
      return mk(dest, p[15:0], p[31:16], 1'b0);
    end
    if (b == 16'h0) return mk(dest, 16'hFFFF, a, 1'b1);
    q = sa / sbv;
    r = sa % sbv;
    return mk(dest, q[15:0], r[15:0], 1'b0);
  endfunction

  // Drives one request once the unit is ready; optionally records its expected write.
  task automatic applyStimulus(input logic opIn, input logic sgn, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] dest, input logic track, input exp_t expIn, output int acc);
    int n;
    exp_t m;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("readyTimeout", 32'(bus.ready), 32'd1);
    bus.op        = opIn;
    bus.data_1    = a;
    bus.data_2    = b;
    bus.dest_addr = dest;
`ifdef MULDIV_SIGNED_EN
    bus.signed_op = sgn;
`endif
    bus.start     = 1'b1;
    acc = cycle + 1;
    if (track) begin
      m = expIn;
      m.doneCycle = acc + WIDTH;
      sb.push_back(m);
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.op        = ~opIn;
    bus.data_1    = ~a;
    bus.data_2    = ~b;
    bus.dest_addr = ~dest;
    checkOutput("busyAfterAccept", 32'(bus.busy), 32'd1);
    checkOutput("readyAfterAccept", 32'(bus.ready), 32'd0);
    checkOutput("divZeroClearedAtAccept", 32'(bus.div_zero), 32'd0);
    checkOutput("resultHiClearedAtAccept", 32'(bus.result_hi), 32'd0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("idleTimeout", 32'(bus.ready), 32'd1);
  endtask

  // Scoreboard consumer: every regWrite pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.regWrite) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousWrite", 32'(bus.regWrite), 32'd0);
      end else begin
        got = sb.pop_front();
        checkOutput("writeAddr", 32'(bus.write_addr), 32'(got.addr));
        checkOutput("writeData", 32'(bus.write_data), 32'(got.lo));
        checkOutput("resultHi", 32'(bus.result_hi), 32'(got.hi));
        checkOutput("divZero", 32'(bus.div_zero), 32'(got.dz));
        checkOutput("doneLatency", 32'(cycle), 32'(got.doneCycle));
        checkOutput("doneWithWrite", 32'(bus.done), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic o;
    logic [15:0] a, b;
    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.data_1    = '0;
    bus.data_2    = '0;
    bus.dest_addr = '0;
`ifdef MULDIV_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rstReady", 32'(bus.ready), 32'd1);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstDone", 32'(bus.done), 32'd0);
    checkOutput("rstRegWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("rstDivZero", 32'(bus.div_zero), 32'd0);
    checkOutput("rstWriteAddr", 32'(bus.write_addr), 32'd0);
    checkOutput("rstWriteData", 32'(bus.write_data), 32'd0);
    checkOutput("rstResultHi", 32'(bus.result_hi), 32'd0);
    rst_n = 1'b1;

    $display("[TB] multiply 0x00FF*0x0101");
    applyStimulus(1'b0, 1'b0, 16'h00FF, 16'h0101, 4'd5, 1'b1, mk(4'd5, 16'hFFFF, 16'h0000, 1'b0), e0);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("holdWriteData", 32'(bus.write_data), 32'h0000FFFF);
    checkOutput("holdWriteAddr", 32'(bus.write_addr), 32'd5);
    checkOutput("idleRegWrite", 32'(bus.regWrite), 32'd0);

    $display("[TB] multiply 0xFFFF*0xFFFF and unsigned divides");
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 4'd1, 1'b1, mk(4'd1, 16'h0001, 16'hFFFE, 1'b0), e0);
    applyStimulus(1'b1, 1'b0, 16'h0064, 16'h0007, 4'd2, 1'b1, mk(4'd2, 16'h000E, 16'h0002, 1'b0), e0);
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000, 4'd3, 1'b1, mk(4'd3, 16'hFFFF, 16'h1234, 1'b1), e0);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("divZeroHeld", 32'(bus.div_zero), 32'd1);
    checkOutput("remainderHeld", 32'(bus.result_hi), 32'h00001234);

    $display("[TB] start during BUSY is ignored");
    applyStimulus(1'b0, 1'b0, 16'h0003, 16'h0005, 4'd7, 1'b1, mk(4'd7, 16'h000F, 16'h0000, 1'b0), e0);
    repeat (2) @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = 1'b1;
    bus.data_1    = 16'h4444;
    bus.dest_addr = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(1'b0, 1'b0, 16'h1111, 16'h0002, 4'd3, 1'b0, mk(4'd0, 16'h0, 16'h0, 1'b0), e0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abortReady", 32'(bus.ready), 32'd1);
    checkOutput("abortBusy", 32'(bus.busy), 32'd0);
    checkOutput("abortWriteData", 32'(bus.write_data), 32'd0);
    checkOutput("abortWriteAddr", 32'(bus.write_addr), 32'd0);
    checkOutput("abortResultHi", 32'(bus.result_hi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 8) @(negedge clk);
    checkOutput("abortNoWrite", 32'(bus.write_data), 32'd0);

    $display("[TB] random unsigned operations, back to back");
    for (int i = 0; i < 8; i++) begin
      o = ((i % 2) == 1);
      a = 16'($urandom);
      b = o ? 16'($urandom_range(1, 600)) : 16'($urandom);
      applyStimulus(o, 1'b0, a, b, 4'(i + 1), 1'b1, model(o, 1'b0, a, b, 4'(i + 1)), e0);
    end
    waitIdle();

`ifdef MULDIV_SIGNED_EN
    $display("[TB] signed operations");
    applyStimulus(1'b0, 1'b1, 16'hFFFA, 16'h0007, 4'd4, 1'b1, mk(4'd4, 16'hFFD6, 16'hFFFF, 1'b0), e0);
    applyStimulus(1'b1, 1'b1, 16'hFFF9, 16'h0002, 4'd6, 1'b1, mk(4'd6, 16'hFFFD, 16'hFFFF, 1'b0), e0);
    applyStimulus(1'b1, 1'b1, 16'h8000, 16'hFFFF, 4'd8, 1'b1, mk(4'd8, 16'h8000, 16'h0000, 1'b0), e0);
    applyStimulus(1'b1, 1'b1, 16'hF00D, 16'h0000, 4'd9, 1'b1, mk(4'd9, 16'hFFFF, 16'hF00D, 1'b1), e0);
    for (int i = 0; i < 6; i++) begin
      o = ((i % 2) == 1);
      a = 16'($urandom);
      b = 16'($urandom_range(1, 2000));
      if (i >= 3) b = -b;
      applyStimulus(o, 1'b1, a, b, 4'(i + 10), 1'b1, model(o, 1'b1, a, b, 4'(i + 10)), e0);
    end
    waitIdle();
`endif

    repeat (4) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
